mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one memory port with a single outstanding transaction.
// Data wins collisions except after MAX_D_STREAK data grants; unanswered requests abort after TIMEOUT cycles.
module mem_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] streak;
  logic [TW-1:0] tcnt;
  logic          busy, ack, tmo, done, fetch_wins;

  assign busy       = (state != IDLE);
  assign ack        = busy && m_req && m_ack;
  // the counter value about to become TIMEOUT; an ack in the same cycle takes precedence
  assign tmo        = busy && !m_ack && (tcnt == TW'(TIMEOUT - 1));
  assign done       = ack || tmo;
  assign fetch_wins = i_req && (!d_req || streak == SW'(MAX_D_STREAK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_gnt)      state_nxt = BUSY_D;
        else if (i_gnt) state_nxt = BUSY_I;
      end
      BUSY_I, BUSY_D: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // grants are combinational in IDLE and held low while reset is asserted
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (state == IDLE && rst_n) begin
      i_gnt = fetch_wins;
      d_gnt = d_req && !fetch_wins;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   streak <= '0;
    else if (i_gnt || (state == IDLE && !i_req)) streak <= '0;
    else if (d_gnt && i_req && streak != SW'(MAX_D_STREAK))
      streak <= streak + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tcnt <= '0;
    else if (i_gnt || d_gnt) tcnt <= '0;
    else if (busy && !m_ack) tcnt <= tcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_be    <= 4'h0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (d_gnt) begin
      m_req   <= 1'b1;
      m_we    <= d_we;
      m_be    <= d_be;
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
    end else if (i_gnt) begin
      m_req   <= 1'b1;
      m_we    <= 1'b0;
      m_be    <= 4'hF;
      m_addr  <= i_addr;
      m_wdata <= '0;
    end else if (done) begin
      m_req   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      i_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= done && (state == BUSY_I);
      i_err    <= tmo && (state == BUSY_I);
      i_rdata  <= (ack && state == BUSY_I) ? m_rdata : '0;
      d_rvalid <= done && (state == BUSY_D);
      d_err    <= tmo && (state == BUSY_D);
      d_rdata  <= (ack && state == BUSY_D && !m_we) ? m_rdata : '0;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int MAXD = 4;
  localparam int TMO  = 255;

  logic        clk, rst_n;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ack;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;

  mem_arbiter #(.MAX_D_STREAK(MAXD), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // transaction-level model: one outstanding command, ack or deadline ends it
  bit          busy, own_d, ig_last, dg_last;
  logic        e_we;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata;
  int          cyc, t_gnt, ack_lat, streak, force_lat;
  bit          force_data_en;
  logic [31:0] force_data;
  bit          rsp_i, rsp_d, rsp_err;
  logic [31:0] rsp_data;
  int          mreq_hi, n_ig, n_dg;

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 99);
    if (r < 2) return 0;
    if (r < 4) return TMO;
    return $urandom_range(1, 4);
  endfunction

  task automatic mem_drive();
    m_ack   = 1'b0;
    m_rdata = force_data_en ? force_data : $urandom;
    if (busy) m_ack = (ack_lat != 0) && (cyc == t_gnt + ack_lat);
    else      m_ack = ($urandom_range(0, 3) == 0);
  endtask

  task automatic compare();
    bit dw, iw;
    dw = !busy && d_req && !(i_req && streak == MAXD);
    iw = !busy && i_req && !dw;
    check("i_gnt", 32'(i_gnt), 32'(iw));
    check("d_gnt", 32'(d_gnt), 32'(dw));
    check("m_req", 32'(m_req), 32'(busy));
    if (busy) begin
      check("m_addr", m_addr, e_addr);
      check("m_we", 32'(m_we), 32'(e_we));
      if (own_d) begin
        check("m_be", 32'(m_be), 32'(e_be));
        check("m_wdata", m_wdata, e_wdata);
      end
    end
    check("i_rvalid", 32'(i_rvalid), 32'(rsp_i));
    check("d_rvalid", 32'(d_rvalid), 32'(rsp_d));
    check("i_err", 32'(i_err), 32'(rsp_i & rsp_err));
    check("d_err", 32'(d_err), 32'(rsp_d & rsp_err));
    if (rsp_i) check("i_rdata", i_rdata, rsp_data);
    if (rsp_d) check("d_rdata", d_rdata, rsp_data);
    if (m_req) mreq_hi++;
    if (i_gnt) n_ig++;
    if (d_gnt) n_dg++;
  endtask

  task automatic update();
    bit dw, iw;
    dw = !busy && d_req && !(i_req && streak == MAXD);
    iw = !busy && i_req && !dw;
    ig_last = 1'b0; dg_last = 1'b0;
    rsp_i = 1'b0; rsp_d = 1'b0; rsp_err = 1'b0; rsp_data = 32'h0;
    if (busy) begin
      if (m_ack) begin
        rsp_i = !own_d; rsp_d = own_d;
        rsp_data = (own_d && e_we) ? 32'h0 : m_rdata;
        busy = 1'b0;
      end else if (cyc - t_gnt == TMO) begin
        rsp_i = !own_d; rsp_d = own_d; rsp_err = 1'b1;
        busy = 1'b0;
      end
    end else begin
      if (dw) begin
        busy = 1'b1; own_d = 1'b1; dg_last = 1'b1;
        e_we = d_we; e_be = d_be; e_addr = d_addr; e_wdata = d_wdata;
        if (i_req && streak < MAXD) streak++;
      end else if (iw) begin
        busy = 1'b1; own_d = 1'b0; ig_last = 1'b1;
        e_we = 1'b0; e_addr = i_addr;
        streak = 0;
      end
      if (!i_req) streak = 0;
      if (busy) begin
        t_gnt   = cyc;
        ack_lat = (force_lat >= 0) ? force_lat : pick_lat();
      end
    end
  endtask

  // caller has driven requester inputs just after the previous posedge
  task automatic run_cycle();
    mem_drive();
    @(negedge clk);
    compare();
    update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < TMO + 4 && busy; k++) run_cycle();
    run_cycle();
  endtask

  task automatic rand_req();
    if (i_req && !ig_last) begin
      if ($urandom_range(0, 15) == 0) i_req = 1'b0;
    end else begin
      i_req  = ($urandom_range(0, 1) == 1);
      i_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (d_req && !dg_last) begin
      if ($urandom_range(0, 15) == 0) d_req = 1'b0;
    end else begin
      d_req   = ($urandom_range(0, 1) == 1);
      d_we    = ($urandom_range(0, 1) == 1);
      d_be    = 4'($urandom_range(0, 15));
      d_addr  = $urandom & 32'hFFFF_FFFC;
      d_wdata = $urandom;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_i_gnt"}, 32'(i_gnt), 32'h0);
    check({tag, "_d_gnt"}, 32'(d_gnt), 32'h0);
    check({tag, "_m_req"}, 32'(m_req), 32'h0);
    check({tag, "_m_addr"}, m_addr, 32'h0);
    check({tag, "_i_rvalid"}, 32'(i_rvalid), 32'h0);
    check({tag, "_d_rvalid"}, 32'(d_rvalid), 32'h0);
    check({tag, "_d_err"}, 32'(d_err), 32'h0);
    check({tag, "_d_rdata"}, d_rdata, 32'h0);
  endtask

  task automatic model_reset();
    busy = 1'b0; streak = 0; ig_last = 1'b0; dg_last = 1'b0;
    rsp_i = 1'b0; rsp_d = 1'b0; rsp_err = 1'b0; rsp_data = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    m_ack = 1'b1; m_rdata = 32'h0;
    model_reset();
    cyc = 0; t_gnt = 0; ack_lat = 0; force_lat = -1;
    force_data_en = 1'b0; force_data = 32'h0;
    own_d = 1'b0; e_we = 1'b0; e_be = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
    mreq_hi = 0; n_ig = 0; n_dg = 0;
    #2;
    check_all_zero("rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1; i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    run_cycle();

    // single fetch, 1-cycle ack with fixed data
    force_lat = 1; force_data_en = 1'b1; force_data = 32'h0000_0013;
    i_req = 1'b1; i_addr = 32'h100;
    run_cycle();
    i_req = 1'b0;
    run_cycle(); run_cycle();
    force_data_en = 1'b0;
    drain();

    // collision: data first, fetch granted in the cycle the data response returns
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h2000; d_wdata = 32'h0;
    run_cycle();
    d_req = 1'b0;
    n_ig = 0;
    run_cycle(); run_cycle();
    check("collision_i_gnt", 32'(n_ig), 32'd1);
    i_req = 1'b0;
    drain();

    // starvation: 4 data grants then 1 fetch grant, repeating
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2004;
    n_ig = 0; n_dg = 0;
    for (int k = 0; k < 30; k++) run_cycle();
    check("starve_d_gnts", 32'(n_dg), 32'd12);
    check("starve_i_gnts", 32'(n_ig), 32'd3);
    drain();

    // store held for 3 cycles before ack
    force_lat = 3;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h3000; d_wdata = 32'hCAFE_BABE;
    run_cycle();
    d_req = 1'b0; mreq_hi = 0;
    for (int k = 0; k < 4; k++) run_cycle();
    check("store_mreq_cycles", 32'(mreq_hi), 32'd3);
    drain();

    // fetch timeout
    force_lat = 0;
    i_req = 1'b1; i_addr = 32'h200;
    run_cycle();
    i_req = 1'b0; mreq_hi = 0;
    for (int k = 0; k < TMO + 1; k++) run_cycle();
    check("timeout_mreq_cycles", 32'(mreq_hi), 32'(TMO));
    drain();

    // reset during a data transaction, then a clean fetch right after release
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    run_cycle();
    d_req = 1'b0;
    run_cycle(); run_cycle();
    rst_n = 1'b0; d_req = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1; d_req = 1'b0;
    force_lat = 2; force_data_en = 1'b1; force_data = 32'hA5A5_0001;
    i_req = 1'b1; i_addr = 32'h400;
    run_cycle();
    i_req = 1'b0;
    for (int k = 0; k < 4; k++) run_cycle();
    force_data_en = 1'b0; force_lat = -1;

    for (int k = 0; k < 4000; k++) begin
      rand_req();
      run_cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
